// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM controller link between the CPU data port and VGA scanout reads.
// Define RAM_ARB_VGA_PRIORITY_EN for fixed VGA priority; the default build uses round-robin.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic              grant_vga_q, grant_vga_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              any_req;
    logic              pick_vga;
`ifndef RAM_ARB_VGA_PRIORITY_EN
    logic              rr_last_vga_q, rr_last_vga_d;
`endif
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              vga_ack_q, vga_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;

    assign any_req = cpu_req | vga_req;

`ifdef RAM_ARB_VGA_PRIORITY_EN
    assign pick_vga = vga_req;
`else
    // On a tie the CPU wins unless it was the last requester served.
    assign pick_vga = vga_req & (~cpu_req | ~rr_last_vga_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_vga_q   <= 1'b0;
            cnt_q         <= '0;
`ifndef RAM_ARB_VGA_PRIORITY_EN
            rr_last_vga_q <= 1'b1;
`endif
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
            vga_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            vga_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_vga_q   <= grant_vga_d;
            cnt_q         <= cnt_d;
`ifndef RAM_ARB_VGA_PRIORITY_EN
            rr_last_vga_q <= rr_last_vga_d;
`endif
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_ack_q     <= cpu_ack_d;
            vga_ack_q     <= vga_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            vga_rdata_q   <= vga_rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_vga_d   = grant_vga_q;
        cnt_d         = cnt_q;
`ifndef RAM_ARB_VGA_PRIORITY_EN
        rr_last_vga_d = rr_last_vga_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_vga_d   = pick_vga;
`ifndef RAM_ARB_VGA_PRIORITY_EN
                    rr_last_vga_d = pick_vga;
`endif
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    state_d = IDLE;
                end else if (RD_LAT <= 1) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d   = 3'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_d == '0) state_d = CAPTURE;
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        vga_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vga_rdata_d = vga_rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    mem_en_d = 1'b1;
                    if (pick_vga) begin
                        mem_addr_d  = vga_addr;
                    end else begin
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    cpu_ack_d = ~grant_vga_q;
                    vga_ack_d = grant_vga_q;
                end
            end
            CAPTURE: begin
                if (grant_vga_q) begin
                    vga_ack_d   = 1'b1;
                    vga_rdata_d = mem_rdata;
                end else begin
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign vga_ack   = vga_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vga_rdata = vga_rdata_q;
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port RAM controller between the CPU core data port and the VGA scanout read port.
- Sits between the core/vga controller and the RAM controller's 32-bit CPU-side link.
- Arbitrates per request and sequences each access through an issue/wait FSM.
- Returns read data and a one-cycle ack to the winning requester.

Parameters:
- ADDR_W, 32: address width on all ports.
- DATA_W, 32: data width on all ports.
- RD_LAT, 1: edges after the mem_en-sampling edge until mem_rdata is valid; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; valid when cpu_ack is high on a read.
- cpu_ack  out  1  one-cycle completion pulse.
- vga_req  in  1  VGA read request; held high until vga_ack.
- vga_addr  in  ADDR_W  VGA address.
- vga_rdata  out  DATA_W  VGA read data; valid when vga_ack is high.
- vga_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  one-cycle access strobe to the RAM controller.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset is asynchronous, active-high. While rst is high:
  - state = IDLE.
  - All outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, vga_ack, cpu_rdata, vga_rdata.
  - rr_last = VGA, so the CPU wins the first tie.
- Reset mid-access abandons the access with no ack. A later re-request is issued afresh.
- All outputs are registered.
- State IDLE:
  - Requests are sampled at the edge.
  - With none pending, stay in IDLE.
  - If only one requester is pending, it wins.
  - If both are pending, the requester not equal to rr_last wins (round-robin).
  - At the edge: latch winner, address, we and wdata onto the mem_* registers; set mem_en = 1; set rr_last = winner; go to ISSUE.
  - VGA accesses always force mem_we = 0.
- State ISSUE (mem_en high for exactly this one cycle):
  - Write: go to IDLE. Winner ack = 1 for the next cycle.
  - Read: load wait counter = RD_LAT-1 and go to WAIT. If RD_LAT = 1, go directly to CAPTURE.
- State WAIT: decrement the counter. At zero, go to CAPTURE.
- State CAPTURE:
  - At the edge: register mem_rdata into the winner's rdata.
  - Pulse the winner's ack for one cycle; the other requester's rdata is unchanged.
  - Go to IDLE.
- Timing with req high before edge E0:
  - mem_en is high during the cycle after E0.
  - Write ack is high during the cycle after E1.
  - Read ack and rdata are visible during the cycle after E1+RD_LAT.
  - For RD_LAT = 1, read ack arrives 2 cycles after E0.
- Ack is a single-cycle pulse. The IDLE state coincides with the ack cycle.
  - A req still high at the edge ending the ack cycle is treated as a new request.
  - Requesters must therefore drop req in the ack cycle unless issuing back-to-back accesses.
- rdata holds its value until that requester's next read completes.
- mem_addr and mem_wdata hold their last value outside ISSUE. mem_we is cleared when leaving ISSUE.
- Requests arriving during ISSUE, WAIT or CAPTURE are not lost: req is level-held and is sampled at the next IDLE.
- The FSM never grants both requesters. cpu_ack and vga_ack are never high in the same cycle.

Optional Feature:
- Macro: RAM_ARB_VGA_PRIORITY_EN.
- Defined: fixed priority. When both requesters are pending in IDLE, VGA always wins. rr_last is unused. The CPU can be starved during back-to-back scanout.
- Undefined: round-robin as specified above.

Test Plan:
- CPU write: cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF -> exactly one mem_en pulse with mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; cpu_ack one cycle, two cycles after req.
- CPU read, RD_LAT=1: model returns 0xCAFEF00D -> cpu_rdata=0xCAFEF00D with cpu_ack 3 cycles after req; vga_rdata stays 0.
- VGA read, RD_LAT=3: vga_addr=0x400 -> mem_we=0, vga_ack 5 cycles after req; no cpu_ack.
- Contention: cpu_req and vga_req both held continuously.
  - Default build: grants alternate CPU, VGA, CPU, VGA after reset.
  - RAM_ARB_VGA_PRIORITY_EN build: VGA granted every time.
- Reset during WAIT (RD_LAT=3, rst pulsed mid-read) -> all outputs 0 immediately, no ack; a re-issued read then completes normally.
- Back-to-back: cpu_req held through ack for 4 writes -> 4 mem_en pulses, one every 2 cycles, with no lost or duplicated access.
